// File: rtl/otf_quotient_converter.sv
// On-the-fly conversion of signed-digit quotients {-1,0,+1} into a WIDTH+1 bit
// two's-complement result. Optional macro OTF_SIGN_CORRECT_EN applies the
// final negative-remainder correction (quotient - 1) when the result is registered.
module otf_quotient_converter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       digit,
  input  logic             digit_valid,
  output logic             digit_ready,
  input  logic             rem_neg,
  output logic [WIDTH:0]   quotient,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             digit_err
);

  localparam int QW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  // Handshakes: a beat transfers on the rising edge where valid & ready are
  // both high; ready never depends on valid, and a producer holds its data
  // stable until the transfer completes.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    state_t         state;
    logic [CW-1:0]  count;
  } dbg_t;

  state_t          state;
  state_t          state_next;
  logic [QW-1:0]   q_reg;
  logic [QW-1:0]   qm_reg;
  logic [QW-1:0]   q_next;
  logic [QW-1:0]   qm_next;
  logic [QW-1:0]   final_value;
  logic [CW-1:0]   count;
  logic            accept;
  logic            last_accept;
  dbg_t            dbg_view_unused;

  // Snapshot of FSM state and digit count for hierarchical probing.
  assign dbg_view_unused = '{state: state, count: count};

  assign accept      = (state == CONVERT) && digit_valid;
  assign last_accept = accept && (count == LAST_COUNT);

  // Shift-in of the next digit; QM always tracks Q - 1.
  always_comb begin
    q_next  = q_reg;
    qm_next = qm_reg;
    case (digit)
      2'b10: begin
        q_next  = {q_reg[WIDTH-1:0], 1'b1};
        qm_next = {q_reg[WIDTH-1:0], 1'b0};
      end
      2'b01: begin
        q_next  = {qm_reg[WIDTH-1:0], 1'b1};
        qm_next = {qm_reg[WIDTH-1:0], 1'b0};
      end
      default: begin
        q_next  = {q_reg[WIDTH-1:0], 1'b0};
        qm_next = {qm_reg[WIDTH-1:0], 1'b1};
      end
    endcase
  end

`ifdef OTF_SIGN_CORRECT_EN
  assign final_value = rem_neg ? qm_next : q_next;
`else
  logic unused_rem_neg;
  assign unused_rem_neg = rem_neg;
  assign final_value    = q_next;
`endif

  always_comb begin
    state_next  = state;
    digit_ready = 1'b0;
    q_valid     = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CONVERT;
      end
      CONVERT: begin
        digit_ready = 1'b1;
        busy        = 1'b1;
        if (last_accept) state_next = DONE;
      end
      DONE: begin
        q_valid = 1'b1;
        busy    = 1'b1;
        if (q_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q_reg     <= '0;
      qm_reg    <= '1;
      count     <= '0;
      quotient  <= '0;
      digit_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        q_reg     <= '0;
        qm_reg    <= '1;
        count     <= '0;
        digit_err <= 1'b0;
      end
      if (accept) begin
        q_reg  <= q_next;
        qm_reg <= qm_next;
        count  <= count + CW'(1);
        if (digit == 2'b11) digit_err <= 1'b1;
        if (last_accept) quotient <= final_value;
      end
    end
  end

endmodule

// File: tb/tb_otf_quotient_converter.sv
// Directed bench for otf_quotient_converter (WIDTH=4): driver tasks issue
// digits and push expected quotients; a monitor pops them when q_valid rises.
module tb_otf_quotient_converter;

  localparam int WIDTH = 4;
  localparam int QW    = WIDTH + 1;

  localparam logic [1:0] DP = 2'b10;
  localparam logic [1:0] DZ = 2'b00;
  localparam logic [1:0] DM = 2'b01;
  localparam logic [1:0] DX = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    digit;
  logic          digit_valid;
  logic          digit_ready;
  logic          rem_neg;
  logic [QW-1:0] quotient;
  logic          q_valid;
  logic          q_ready;
  logic          busy;
  logic          digit_err;

  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q[$];
  logic          seen = 1'b0;

  otf_quotient_converter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .rem_neg     (rem_neg),
    .quotient    (quotient),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .busy        (busy),
    .digit_err   (digit_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard pop per q_valid episode.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: unexpected quotient %0h", quotient);
        end else begin
          check("quotient", 32'(quotient), 32'(exp_q.pop_front()));
        end
      end else if (!q_valid) begin
        seen = 1'b0;
      end
    end
  end

  // Driver tasks: all entered and left at a falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_digit(input logic [1:0] d, input int gap, input logic rn);
    int tmo;
    repeat (gap) begin
      digit_valid = 1'b0;
      @(negedge clk);
      check("ready_in_gap", 32'(digit_ready), 32'd1);
    end
    digit       = d;
    digit_valid = 1'b1;
    rem_neg     = rn;
    tmo = 0;
    while (!digit_ready && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 20) check("digit_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    digit_valid = 1'b0;
    rem_neg     = 1'b0;
  endtask

  task automatic run4(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2,
                      input logic [1:0] d3, input int gap, input logic rn_last);
    send_digit(d0, gap, 1'b0);
    send_digit(d1, gap, 1'b0);
    send_digit(d2, gap, 1'b0);
    send_digit(d3, gap, rn_last);
    check("latency_q_valid", 32'(q_valid), 32'd1);
  endtask

  task automatic consume(input logic [QW-1:0] exp, input int hold, input logic with_start);
    int tmo;
    tmo = 0;
    while (!q_valid && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 20) check("q_valid_timeout", 32'd0, 32'd1);
    q_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("hold_q_valid", 32'(q_valid), 32'd1);
      check("hold_quotient", 32'(quotient), 32'(exp));
    end
    q_ready = 1'b1;
    start   = with_start;
    @(negedge clk);
    q_ready = 1'b0;
    start   = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_q_valid", 32'(q_valid), 32'd0);
    check("idle_quotient_kept", 32'(quotient), 32'(exp));
    if (with_start) begin
      @(negedge clk);
      check("start_with_ready_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [QW-1:0] exp_corr;
    rst_n = 1'b0; start = 1'b0; digit = 2'b00; digit_valid = 1'b0;
    rem_neg = 1'b0; q_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_q_valid", 32'(q_valid), 32'd0);
    check("rst_digit_ready", 32'(digit_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_digit_err", 32'(digit_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // +1,0,-1,+1 back-to-back -> 7
    do_start();
    check("convert_busy", 32'(busy), 32'd1);
    exp_q.push_back(5'b00111);
    run4(DP, DZ, DM, DP, 0, 1'b0);
    check("err_clean", 32'(digit_err), 32'd0);
    consume(5'b00111, 0, 1'b0);

    // all -1 -> -15, all 0 -> 0
    do_start();
    exp_q.push_back(5'b10001);
    run4(DM, DM, DM, DM, 0, 1'b0);
    consume(5'b10001, 0, 1'b0);
    do_start();
    exp_q.push_back(5'b00000);
    run4(DZ, DZ, DZ, DZ, 0, 1'b0);
    consume(5'b00000, 0, 1'b0);

    // gapped +1s, consumer stalls 5 cycles
    do_start();
    exp_q.push_back(5'b01111);
    run4(DP, DP, DP, DP, 3, 1'b0);
    consume(5'b01111, 5, 1'b0);

    // illegal digit behaves as 0 and sets sticky error; start+q_ready in DONE
    do_start();
    exp_q.push_back(5'b01000);
    run4(DP, DX, DZ, DZ, 0, 1'b0);
    check("err_set", 32'(digit_err), 32'd1);
    consume(5'b01000, 0, 1'b1);
    check("err_sticky_idle", 32'(digit_err), 32'd1);
    do_start();
    check("err_cleared_by_start", 32'(digit_err), 32'd0);
    exp_q.push_back(5'b00000);
    run4(DZ, DZ, DZ, DZ, 0, 1'b0);
    consume(5'b00000, 0, 1'b0);

    // mid-conversion async reset on a nonzero held quotient
    do_start();
    exp_q.push_back(5'b01111);
    run4(DP, DP, DP, DP, 0, 1'b0);
    consume(5'b01111, 0, 1'b0);
    do_start();
    send_digit(DP, 0, 1'b0);
    send_digit(DP, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q_valid", 32'(q_valid), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_ready", 32'(digit_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    exp_q.push_back(5'b00001);
    send_digit(DZ, 0, 1'b0);
    send_digit(DZ, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_digit(DZ, 0, 1'b0);
    send_digit(DP, 0, 1'b0);
    check("latency_q_valid", 32'(q_valid), 32'd1);
    consume(5'b00001, 0, 1'b0);

    // final sign correction
`ifdef OTF_SIGN_CORRECT_EN
    exp_corr = 5'b00111;
`else
    exp_corr = 5'b01000;
`endif
    do_start();
    exp_q.push_back(exp_corr);
    run4(DP, DZ, DZ, DZ, 0, 1'b1);
    consume(exp_corr, 0, 1'b0);
    do_start();
    exp_q.push_back(5'b01000);
    run4(DP, DZ, DZ, DZ, 0, 1'b0);
    consume(5'b01000, 0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
